keypad_display_motor_ctrl: RTL and testbench

//  User front-end of the RGB dosing controller: scans a 4x4 keypad and reports numeric digits,

---
 rtl/keypad_display_motor_ctrl.sv | 148 ++++++++++++++
 tb/tb_keypad_display_motor_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_display_motor_ctrl.sv
// keypad_display_motor_ctrl: keypad scanner, 3-digit 7-seg multiplexer and RGB motor sequencer
module keypad_display_motor_ctrl #(
  parameter int SCAN_DIV = 1000000,
  parameter int MUX_DIV  = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] fila,
  output logic [3:0] col,
  output logic [4:0] digito,
  output logic       cambio_digito,
  input  logic [4:0] c,
  input  logic [4:0] d,
  input  logic [4:0] u,
  output logic [2:0] enable,
  output logic [6:0] segmentos,
  input  logic       RGB_full,
  input  logic [2:0] flags,
  input  logic       enter,
  output logic [2:0] Motores
);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int MW = $clog2(MUX_DIV);
  typedef enum logic [2:0] {IDLE, LOADED, RUN_R, RUN_G, RUN_B} state_t;
  state_t      r_state;
  logic [SW-1:0] r_scan_cnt;
  logic [MW-1:0] r_mux_cnt;
  logic        r_held;
  logic [2:0]  r_en_sync;
  logic        w_scan_tick;
  logic        w_mux_tick;
  logic        w_start;
  logic [1:0]  w_row;
  logic [1:0]  w_colk;
  logic        w_num;
  logic [4:0]  w_val;
  logic [2:0]  w_en_nxt;
  logic [4:0]  w_sel;
  logic [6:0]  w_glyph;
  // Tick strobes, key decode and next display slot selection
  always_comb begin
    w_scan_tick = r_scan_cnt == SW'(SCAN_DIV - 1);
    w_mux_tick  = r_mux_cnt == MW'(MUX_DIV - 1);
    w_start     = r_en_sync[1] & ~r_en_sync[2];
    w_row       = !fila[0] ? 2'd0 : !fila[1] ? 2'd1 : !fila[2] ? 2'd2 : 2'd3;
    w_colk      = !col[0] ? 2'd0 : !col[1] ? 2'd1 : !col[2] ? 2'd2 : 2'd3;
    w_num       = (w_row != 2'd3 && w_colk != 2'd3) || (w_row == 2'd3 && w_colk == 2'd1);
    w_val       = (w_row == 2'd3) ? 5'd0 : 5'd3 * {3'd0, w_row} + {3'd0, w_colk} + 5'd1;
    w_en_nxt    = {enable[1:0], enable[2]};
    w_sel       = !w_en_nxt[0] ? u : !w_en_nxt[1] ? d : c;
  end
  // Active-low glyph for the value about to be shown; 16..31 render as a dash
  always_comb begin
    case (w_sel)
      5'd0:    w_glyph = 7'b1000000;
      5'd1:    w_glyph = 7'b1111001;
      5'd2:    w_glyph = 7'b0100100;
      5'd3:    w_glyph = 7'b0110000;
      5'd4:    w_glyph = 7'b0011001;
      5'd5:    w_glyph = 7'b0010010;
      5'd6:    w_glyph = 7'b0000010;
      5'd7:    w_glyph = 7'b1111000;
      5'd8:    w_glyph = 7'b0000000;
      5'd9:    w_glyph = 7'b0010000;
      5'd10:   w_glyph = 7'b0001000;
      5'd11:   w_glyph = 7'b0000011;
      5'd12:   w_glyph = 7'b1000110;
      5'd13:   w_glyph = 7'b0100001;
      5'd14:   w_glyph = 7'b0000110;
      5'd15:   w_glyph = 7'b0001110;
      default: w_glyph = 7'b0111111;
    endcase
  end
  // Keypad scan: rotate columns, freeze on a press, emit one digit pulse per press
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scan_cnt    <= '0;
      col           <= 4'b1110;
      r_held        <= 1'b0;
      digito        <= 5'd0;
      cambio_digito <= 1'b0;
    end else begin
      cambio_digito <= 1'b0;
      r_scan_cnt    <= w_scan_tick ? '0 : r_scan_cnt + 1'b1;
      if (w_scan_tick) begin
        if (r_held) r_held <= fila != 4'hF;
        else if (fila != 4'hF) begin
          r_held <= 1'b1;
          if (w_num) begin
            digito        <= w_val;
            cambio_digito <= 1'b1;
          end
        end else col <= {col[2:0], col[3]};
      end
    end
  end
  // Display mux: segments load together with the new digit select so no ghosting
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mux_cnt <= '0;
      enable    <= 3'b110;
      segmentos <= 7'b1111111;
    end else begin
      r_mux_cnt <= w_mux_tick ? '0 : r_mux_cnt + 1'b1;
      if (w_mux_tick) begin
        enable    <= w_en_nxt;
        segmentos <= w_glyph;
      end
    end
  end
  // Enter synchronizer and previous-value flop for rising-edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_en_sync <= 3'b000;
    else r_en_sync <= {r_en_sync[1:0], enter};
  end
  // Motor sequencer with registered one-hot motor enables
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      Motores <= 3'b000;
    end else begin
      case (r_state)
        IDLE:    if (RGB_full) r_state <= LOADED;
        LOADED:  if (!RGB_full) r_state <= IDLE;
                 else if (w_start) begin
                   r_state <= RUN_R;
                   Motores <= 3'b100;
                 end
        RUN_R:   if (flags[2]) begin
                   r_state <= RUN_G;
                   Motores <= 3'b010;
                 end
        RUN_G:   if (flags[1]) begin
                   r_state <= RUN_B;
                   Motores <= 3'b001;
                 end
        RUN_B:   if (flags[0]) begin
                   r_state <= IDLE;
                   Motores <= 3'b000;
                 end
        default: begin
                   r_state <= IDLE;
                   Motores <= 3'b000;
                 end
      endcase
    end
  end
endmodule

// File: tb/tb_keypad_display_motor_ctrl.sv
// tb_keypad_display_motor_ctrl: scoreboard bench for keypad, display and motor sequencing
module tb_keypad_display_motor_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] fila;
  logic [3:0] col;
  logic [4:0] digito;
  logic       cambio_digito;
  logic [4:0] c, d, u;
  logic [2:0] enable;
  logic [6:0] segmentos;
  logic       RGB_full;
  logic [2:0] flags;
  logic       enter;
  logic [2:0] Motores;
  int n_vec = 0;
  int n_err = 0;
  int dsp_n = 0;
  logic [4:0] kq[$];
  logic [2:0] mq[$];
  logic [2:0] mprev = 3'b000;
  logic [2:0] dprev = 3'b110;
  logic [4:0] sc, sd, su;
  string keys[4] = '{"123A", "456B", "789C", "*0#D"};
  string lit[16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                     "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};
  logic [2:0] dseq[3] = '{3'b110, 3'b101, 3'b011};

  keypad_display_motor_ctrl #(.SCAN_DIV(4), .MUX_DIV(4)) dut (
    .clk(clk), .reset(reset), .fila(fila), .col(col), .digito(digito),
    .cambio_digito(cambio_digito), .c(c), .d(d), .u(u), .enable(enable),
    .segmentos(segmentos), .RGB_full(RGB_full), .flags(flags), .enter(enter),
    .Motores(Motores)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] glyph(logic [4:0] v);
    logic [6:0] r = 7'h7F;
    if (v > 5'd15) return 7'b0111111;
    for (int i = 0; i < lit[v].len(); i++) r[int'(lit[v].getc(i)) - 97] = 1'b0;
    return r;
  endfunction

  // Display inputs as seen at the clock edge the DUT used
  always @(posedge clk) begin
    sc <= c;
    sd <= d;
    su <= u;
  end

  // Display monitor: each slot change must follow the rotation and show the right glyph
  always @(negedge clk) begin
    if (reset) dprev = 3'b110;
    else if (enable != dprev) begin
      int idx = 0;
      for (int i = 0; i < 3; i++) if (dseq[i] == dprev) idx = i;
      check("enable_order", enable, dseq[(idx + 1) % 3]);
      check("segmentos", segmentos,
            glyph(enable == 3'b110 ? su : enable == 3'b101 ? sd : sc));
      dsp_n++;
      dprev = enable;
    end
  end

  // Keypad monitor: every digit pulse consumes one expected digit
  always @(negedge clk) begin
    if (cambio_digito) begin
      if (kq.size() == 0) check("spurious_pulse", cambio_digito, 0);
      else check("digito", digito, kq.pop_front());
    end
  end

  // Motor monitor: every change of Motores consumes one expected value
  always @(negedge clk) begin
    if (Motores != mprev) begin
      if (mq.size() == 0) check("motor_unexpected", Motores, mprev);
      else check("motores", Motores, mq.pop_front());
      mprev = Motores;
    end
  end

  task automatic press(int row, int k, int hold);
    logic [3:0] tgt = ~(4'b0001 << k);
    byte ch = keys[row].getc(k);
    bit ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = col == tgt;
    end
    check("col_reach", ok, 1);
    c = 5'($urandom_range(0, 31));
    d = 5'($urandom_range(0, 31));
    u = 5'($urandom_range(0, 31));
    fila = ~(4'b0001 << row);
    if (ch >= "0" && ch <= "9") kq.push_back(5'(ch - "0"));
    repeat (hold * 4 + 4) @(negedge clk);
    check("col_frozen", col, tgt);
    fila = 4'hF;
    repeat (12) @(negedge clk);
    check("col_resumed", col != tgt, 1);
  endtask

  task automatic wait_mot(logic [2:0] m);
    bit ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = Motores == m;
    end
    check("motor_reach", ok, 1);
  endtask

  task automatic start_run();
    RGB_full = 1'b1;
    repeat (3) @(negedge clk);
    enter = 1'b1;
    mq.push_back(3'b100);
    repeat (2) @(negedge clk);
    check("start_latency_pre", Motores, 3'b000);
    @(negedge clk);
    check("start_latency", Motores, 3'b100);
    enter = 1'b0;
  endtask

  task automatic run(bit step, bit inject);
    start_run();
    if (inject) begin
      repeat (2) @(negedge clk);
      enter = 1'b1;
      repeat (4) @(negedge clk);
      enter = 1'b0;
      check("no_restart", Motores, 3'b100);
    end
    if (step) begin
      for (int i = 2; i >= 0; i--) begin
        logic [2:0] e = (i == 0) ? 3'b000 : 3'(1 << (i - 1));
        repeat ($urandom_range(0, 4)) @(negedge clk);
        flags = 3'(1 << i);
        mq.push_back(e);
        wait_mot(e);
        flags = 3'b000;
      end
    end else begin
      mq.push_back(3'b010);
      mq.push_back(3'b001);
      mq.push_back(3'b000);
      flags = 3'b111;
      wait_mot(3'b000);
      flags = 3'b000;
    end
    repeat (4) @(negedge clk);
    check("motor_queue_empty", mq.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    fila = 4'hF;
    c = 5'd3;
    d = 5'd10;
    u = 5'd20;
    RGB_full = 1'b0;
    flags = 3'b000;
    enter = 1'b0;
    #1;
    check("rst_col", col, 4'b1110);
    check("rst_digito", digito, 0);
    check("rst_cambio", cambio_digito, 0);
    check("rst_enable", enable, 3'b110);
    check("rst_seg", segmentos, 7'h7F);
    check("rst_motores", Motores, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("col_hold", col, 4'b1110);
    @(negedge clk);
    check("col_step1", col, 4'b1101);
    repeat (4) @(negedge clk);
    check("col_step2", col, 4'b1011);
    repeat (4) @(negedge clk);
    check("col_step3", col, 4'b0111);
    repeat (8) @(negedge clk);
    press(1, 2, 3);
    check("digito_6", digito, 6);
    press(3, 2, 1);
    check("digito_hash", digito, 6);
    press(3, 1, 2);
    check("digito_0", digito, 0);
    for (int i = 0; i < 10; i++) press($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(1, 5));
    check("key_queue_empty", kq.size(), 0);
    for (int i = 0; i < 4; i++) run(1'($urandom_range(0, 1)), i == 1);
    start_run();
    flags = 3'b100;
    mq.push_back(3'b010);
    wait_mot(3'b010);
    flags = 3'b000;
    #3;
    mq.push_back(3'b000);
    reset = 1'b1;
    #1;
    check("async_motores", Motores, 0);
    check("async_col", col, 4'b1110);
    check("async_enable", enable, 3'b110);
    @(posedge clk);
    @(negedge clk);
    #2;
    reset = 1'b0;
    RGB_full = 1'b1;
    repeat (3) @(negedge clk);
    RGB_full = 1'b0;
    repeat (2) @(negedge clk);
    enter = 1'b1;
    repeat (3) @(negedge clk);
    enter = 1'b0;
    repeat (10) @(negedge clk);
    check("no_start_unloaded", Motores, 0);
    check("motor_queue_final", mq.size(), 0);
    check("display_activity", dsp_n > 20, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
